// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side view of the hazard controller. The slave
// modport is the controller itself. The master modport is the pipeline
// datapath that drives register addresses and collects the stage controls.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] ifid_reg1_raddr;
    logic [ADDR_W-1:0] ifid_reg2_raddr;
    logic              ifid_reg1_rena;
    logic              ifid_reg2_rena;
    logic [ADDR_W-1:0] idex_reg_waddr;
    logic              idex_mem_rena;
    logic [ADDR_W-1:0] idex_reg1_raddr;
    logic [ADDR_W-1:0] idex_reg2_raddr;
    logic [ADDR_W-1:0] exmem_reg_waddr;
    logic [ADDR_W-1:0] memwb_reg_waddr;
    logic              exmem_reg_wena;
    logic              memwb_reg_wena;
    logic              ex_branch_taken;
    logic              mc_start;
    logic              mc_done;
    logic              pc_continue;
    logic              ifid_continue;
    logic              idex_continue;
    logic              exmem_continue;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              mc_timeout;
    logic [15:0]       stall_cycles;

    modport master (
        output ifid_reg1_raddr, ifid_reg2_raddr, ifid_reg1_rena, ifid_reg2_rena,
        output idex_reg_waddr, idex_mem_rena, idex_reg1_raddr, idex_reg2_raddr,
        output exmem_reg_waddr, memwb_reg_waddr, exmem_reg_wena, memwb_reg_wena,
        output ex_branch_taken, mc_start, mc_done,
        input  pc_continue, ifid_continue, idex_continue, exmem_continue,
        input  ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel,
        input  mc_timeout, stall_cycles
    );

    modport slave (
        input  ifid_reg1_raddr, ifid_reg2_raddr, ifid_reg1_rena, ifid_reg2_rena,
        input  idex_reg_waddr, idex_mem_rena, idex_reg1_raddr, idex_reg2_raddr,
        input  exmem_reg_waddr, memwb_reg_waddr, exmem_reg_wena, memwb_reg_wena,
        input  ex_branch_taken, mc_start, mc_done,
        output pc_continue, ifid_continue, idex_continue, exmem_continue,
        output ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel,
        output mc_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for a 5-stage pipeline.
// This block handles load-use stalls, branch flushes, multi-cycle EX freezes
// with a watchdog timeout, and operand forwarding from EX/MEM and MEM/WB.
module hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int MC_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, LSTALL, MCWAIT} state_t;

    localparam logic [2:0]        LOAD_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [15:0]       MC_LIMIT    = 16'(MC_TIMEOUT);
    localparam logic [ADDR_W-1:0] REG_X0      = '0;

    state_t      state;
    state_t      next_state;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;
    logic [15:0] mc_cnt;
    logic [15:0] mc_cnt_next;
    logic        timeout_hit;
    logic        load_use;
    logic        mc_begin;

    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] em_addr,
        input logic              em_we,
        input logic [ADDR_W-1:0] mw_addr,
        input logic              mw_we
    );
        if (em_we && (em_addr != REG_X0) && (em_addr == src)) begin
            return 2'b10;
        end
        if (mw_we && (mw_addr != REG_X0) && (mw_addr == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Decode the raw hazard conditions; x0 is never a real load destination.
    always_comb begin
        load_use = bus.idex_mem_rena && (bus.idex_reg_waddr != REG_X0) &&
                   ((bus.ifid_reg1_rena && (bus.ifid_reg1_raddr == bus.idex_reg_waddr)) ||
                    (bus.ifid_reg2_rena && (bus.ifid_reg2_raddr == bus.idex_reg_waddr)));
        mc_begin = bus.mc_start && !bus.mc_done;
    end

    // State and stall counters; reset aborts any stall in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RUN;
            cnt    <= '0;
            mc_cnt <= '0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            mc_cnt <= mc_cnt_next;
        end
    end

    // Next-state logic: branch beats multi-cycle start beats load-use in RUN.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        mc_cnt_next = mc_cnt;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    next_state = RUN;
                end else if (mc_begin) begin
                    next_state  = MCWAIT;
                    mc_cnt_next = 16'd1;
                end else if (!bus.mc_start && load_use && (LOAD_STALL > 1)) begin
                    next_state = LSTALL;
                    cnt_next   = LOAD_RELOAD;
                end
            end
            LSTALL: begin
                if (bus.ex_branch_taken) begin
                    next_state = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        next_state = RUN;
                    end
                end
            end
            MCWAIT: begin
                if (bus.mc_done) begin
                    next_state  = RUN;
                    mc_cnt_next = '0;
                end else if (mc_cnt == MC_LIMIT) begin
                    next_state  = RUN;
                    mc_cnt_next = '0;
                    timeout_hit = 1'b1;
                end else begin
                    mc_cnt_next = mc_cnt + 16'd1;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Stage advance and flush controls; held at free-running values in reset.
    always_comb begin
        bus.pc_continue    = 1'b1;
        bus.ifid_continue  = 1'b1;
        bus.idex_continue  = 1'b1;
        bus.exmem_continue = 1'b1;
        bus.ifid_flush     = 1'b0;
        bus.idex_flush     = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (bus.ex_branch_taken) begin
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else if (mc_begin) begin
                        bus.pc_continue    = 1'b0;
                        bus.ifid_continue  = 1'b0;
                        bus.idex_continue  = 1'b0;
                        bus.exmem_continue = 1'b0;
                    end else if (!bus.mc_start && load_use) begin
                        bus.pc_continue   = 1'b0;
                        bus.ifid_continue = 1'b0;
                        bus.idex_flush    = 1'b1;
                    end
                end
                LSTALL: begin
                    if (bus.ex_branch_taken) begin
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end else begin
                        bus.pc_continue   = 1'b0;
                        bus.ifid_continue = 1'b0;
                        bus.idex_flush    = 1'b1;
                    end
                end
                MCWAIT: begin
                    if (!bus.mc_done && (mc_cnt != MC_LIMIT)) begin
                        bus.pc_continue    = 1'b0;
                        bus.ifid_continue  = 1'b0;
                        bus.idex_continue  = 1'b0;
                        bus.exmem_continue = 1'b0;
                    end
                end
                default: begin
                    bus.pc_continue = 1'b1;
                end
            endcase
        end
    end

    // Operand bypass selection; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        bus.fwd_a_sel = 2'b00;
        bus.fwd_b_sel = 2'b00;
        if (rst) begin
            bus.fwd_a_sel = fwd_sel(bus.idex_reg1_raddr, bus.exmem_reg_waddr,
                                    bus.exmem_reg_wena, bus.memwb_reg_waddr, bus.memwb_reg_wena);
            bus.fwd_b_sel = fwd_sel(bus.idex_reg2_raddr, bus.exmem_reg_waddr,
                                    bus.exmem_reg_wena, bus.memwb_reg_waddr, bus.memwb_reg_wena);
        end
    end

    // Sticky timeout flag and saturating count of cycles with the PC held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.mc_timeout   <= 1'b0;
            bus.stall_cycles <= '0;
        end else begin
            if (timeout_hit) begin
                bus.mc_timeout <= 1'b1;
            end
            if (!bus.pc_continue && (bus.stall_cycles != 16'hFFFF)) begin
                bus.stall_cycles <= bus.stall_cycles + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives two hazard_ctrl instances (LOAD_STALL 3 and 1, both
// MC_TIMEOUT 8) with identical inputs and compares them against a cycle
// model, a vector table and hand-written multi-cycle sequences.
module tb_hazard_ctrl;
    typedef struct packed {
        logic [4:0] r1;
        logic [4:0] r2;
        logic       r1_en;
        logic       r2_en;
        logic [4:0] ld_dst;
        logic       ld;
        logic [4:0] ex_r1;
        logic [4:0] ex_r2;
        logic [4:0] em_dst;
        logic       em_we;
        logic [4:0] mw_dst;
        logic       mw_we;
        logic       br;
        logic       mcs;
        logic       mcd;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       idex;
        logic       exmem;
        logic       ff;
        logic       xf;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct packed {
        int load_left;
        bit mc_busy;
        int frozen;
        bit timeout;
        int stalls;
    } mdl_t;

    typedef struct {
        in_t   stim;
        out_t  want;
        string tag;
    } vec_t;

    localparam out_t OUT_NONE   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    localparam out_t OUT_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
    localparam out_t OUT_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
    localparam mdl_t MDL_RESET  = '{0, 1'b0, 0, 1'b0, 0};
    localparam int   T_LIM      = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   seen3;
    int   seen1;
    mdl_t m3;
    mdl_t m1;
    out_t act3;
    out_t act1;
    out_t last3;
    out_t last1;

    hazard_ctrl_if #(.ADDR_W(5)) bus3 ();
    hazard_ctrl_if #(.ADDR_W(5)) bus1 ();

    hazard_ctrl #(.ADDR_W(5), .LOAD_STALL(3), .MC_TIMEOUT(T_LIM)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );
    hazard_ctrl #(.ADDR_W(5), .LOAD_STALL(1), .MC_TIMEOUT(T_LIM)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    assign act3 = {bus3.pc_continue, bus3.ifid_continue, bus3.idex_continue, bus3.exmem_continue,
                   bus3.ifid_flush, bus3.idex_flush, bus3.fwd_a_sel, bus3.fwd_b_sel};
    assign act1 = {bus1.pc_continue, bus1.ifid_continue, bus1.idex_continue, bus1.exmem_continue,
                   bus1.ifid_flush, bus1.idex_flush, bus1.fwd_a_sel, bus1.fwd_b_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A load hazard: the loaded register (not x0) is read by an enabled ID source.
    function automatic bit hazard_ref(in_t s);
        if (!s.ld || s.ld_dst == 5'd0) return 1'b0;
        return (s.r1_en && s.r1 == s.ld_dst) || (s.r2_en && s.r2 == s.ld_dst);
    endfunction

    // Newest producer of a non-zero register supplies the operand.
    function automatic logic [1:0] fwd_ref(logic [4:0] src, in_t s);
        if (src == 5'd0) return 2'b00;
        if (s.em_we && s.em_dst == src) return 2'b10;
        if (s.mw_we && s.mw_dst == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model_out(mdl_t m, in_t s, logic rst_n, int t_lim);
        out_t o;
        o = OUT_NONE;
        if (!rst_n) return o;
        o.fa = fwd_ref(s.ex_r1, s);
        o.fb = fwd_ref(s.ex_r2, s);
        if (m.mc_busy) begin
            if (!s.mcd && m.frozen < t_lim) {o.pc, o.ifid, o.idex, o.exmem} = 4'b0000;
        end else if (m.load_left > 0 || (!s.br && !s.mcs && hazard_ref(s))) begin
            if (s.br) {o.ff, o.xf} = 2'b11;
            else begin
                {o.pc, o.ifid} = 2'b00;
                o.xf = 1'b1;
            end
        end else if (s.br) begin
            {o.ff, o.xf} = 2'b11;
        end else if (s.mcs && !s.mcd) begin
            {o.pc, o.ifid, o.idex, o.exmem} = 4'b0000;
        end
        return o;
    endfunction

    function automatic mdl_t model_next(mdl_t m, in_t s, logic rst_n, int l_stall, int t_lim, out_t o);
        mdl_t n;
        if (!rst_n) return MDL_RESET;
        n = m;
        if (!o.pc && n.stalls < 65535) n.stalls = n.stalls + 1;
        if (m.mc_busy) begin
            if (s.mcd) n.mc_busy = 1'b0;
            else if (m.frozen >= t_lim) begin
                n.mc_busy = 1'b0;
                n.timeout = 1'b1;
            end else n.frozen = m.frozen + 1;
        end else if (m.load_left > 0) begin
            n.load_left = s.br ? 0 : m.load_left - 1;
        end else if (!s.br && s.mcs && !s.mcd) begin
            n.mc_busy = 1'b1;
            n.frozen  = 1;
        end else if (!s.br && !s.mcs && hazard_ref(s)) begin
            n.load_left = l_stall - 1;
        end
        return n;
    endfunction

    task automatic applyStimulus(input in_t s);
        bus3.ifid_reg1_raddr = s.r1;      bus1.ifid_reg1_raddr = s.r1;
        bus3.ifid_reg2_raddr = s.r2;      bus1.ifid_reg2_raddr = s.r2;
        bus3.ifid_reg1_rena  = s.r1_en;   bus1.ifid_reg1_rena  = s.r1_en;
        bus3.ifid_reg2_rena  = s.r2_en;   bus1.ifid_reg2_rena  = s.r2_en;
        bus3.idex_reg_waddr  = s.ld_dst;  bus1.idex_reg_waddr  = s.ld_dst;
        bus3.idex_mem_rena   = s.ld;      bus1.idex_mem_rena   = s.ld;
        bus3.idex_reg1_raddr = s.ex_r1;   bus1.idex_reg1_raddr = s.ex_r1;
        bus3.idex_reg2_raddr = s.ex_r2;   bus1.idex_reg2_raddr = s.ex_r2;
        bus3.exmem_reg_waddr = s.em_dst;  bus1.exmem_reg_waddr = s.em_dst;
        bus3.exmem_reg_wena  = s.em_we;   bus1.exmem_reg_wena  = s.em_we;
        bus3.memwb_reg_waddr = s.mw_dst;  bus1.memwb_reg_waddr = s.mw_dst;
        bus3.memwb_reg_wena  = s.mw_we;   bus1.memwb_reg_wena  = s.mw_we;
        bus3.ex_branch_taken = s.br;      bus1.ex_branch_taken = s.br;
        bus3.mc_start        = s.mcs;     bus1.mc_start        = s.mcs;
        bus3.mc_done         = s.mcd;     bus1.mc_done         = s.mcd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] required);
        checks = checks + 1;
        if (actual !== required) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, required);
        end
    endtask

    task automatic step(input in_t s, input string tag);
        out_t e3;
        out_t e1;
        applyStimulus(s);
        #4;
        e3 = model_out(m3, s, rst, T_LIM);
        e1 = model_out(m1, s, rst, T_LIM);
        last3 = act3;
        last1 = act1;
        if (act3.pc === 1'b0) seen3 = seen3 + 1;
        if (act1.pc === 1'b0) seen1 = seen1 + 1;
        checkOutput({tag, " L3 ctrl"}, 32'(act3), 32'(e3));
        checkOutput({tag, " L1 ctrl"}, 32'(act1), 32'(e1));
        checkOutput({tag, " L3 stall_cycles"}, 32'(bus3.stall_cycles), 32'(m3.stalls));
        checkOutput({tag, " L1 stall_cycles"}, 32'(bus1.stall_cycles), 32'(m1.stalls));
        checkOutput({tag, " L3 mc_timeout"}, 32'(bus3.mc_timeout), 32'(m3.timeout));
        checkOutput({tag, " L1 mc_timeout"}, 32'(bus1.mc_timeout), 32'(m1.timeout));
        m3 = model_next(m3, s, rst, 3, T_LIM, e3);
        m1 = model_next(m1, s, rst, 1, T_LIM, e1);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t rand_in();
        in_t s;
        s.r1     = 5'($urandom_range(0, 7));
        s.r2     = 5'($urandom_range(0, 7));
        s.r1_en  = 1'($urandom_range(0, 1));
        s.r2_en  = 1'($urandom_range(0, 1));
        s.ld_dst = 5'($urandom_range(0, 7));
        s.ld     = 1'($urandom_range(0, 1));
        s.ex_r1  = 5'($urandom_range(0, 7));
        s.ex_r2  = 5'($urandom_range(0, 7));
        s.em_dst = 5'($urandom_range(0, 7));
        s.em_we  = 1'($urandom_range(0, 1));
        s.mw_dst = 5'($urandom_range(0, 7));
        s.mw_we  = 1'($urandom_range(0, 1));
        s.br     = ($urandom_range(0, 7) == 0);
        s.mcs    = ($urandom_range(0, 15) == 0);
        s.mcd    = ($urandom_range(0, 4) == 0);
        return s;
    endfunction

    initial begin
        vec_t vecs[12];
        in_t  idle;
        in_t  s;
        in_t  lu;
        int   base;

        checks = 0;
        errors = 0;
        seen3  = 0;
        seen1  = 0;
        idle   = '0;
        lu     = '0;
        lu.r1 = 5'd5; lu.r1_en = 1'b1; lu.ld_dst = 5'd5; lu.ld = 1'b1;

        //           r1     r2     e1    e2    lddst  ld    exr1   exr2   emdst  emwe  mwdst  mwwe  br    mcs   mcd
        vecs[0]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_NONE, "none"};
        vecs[1]  = '{'{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_STALL, "loaduse_r1"};
        vecs[2]  = '{'{5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_STALL, "loaduse_r2"};
        vecs[3]  = '{'{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_NONE, "load_x0"};
        vecs[4]  = '{'{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_NONE, "load_rena0"};
        vecs[5]  = '{'{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, OUT_NONE, "not_load"};
        vecs[6]  = '{'{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}, OUT_FLUSH, "branch_over_load"};
        vecs[7]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1}, OUT_NONE, "mc_start_done"};
        vecs[8]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00}, "fwd_double_x7"};
        vecs[9]  = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00}, "fwd_exmem_x0"};
        vecs[10] = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0},
                     '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01}, "fwd_b_memwb"};
        vecs[11] = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}, OUT_NONE, "fwd_x0"};

        rst = 1'b0;
        applyStimulus(idle);
        @(posedge clk);
        #1;
        m3 = MDL_RESET;
        m1 = MDL_RESET;

        s = lu; s.br = 1'b1; s.mcs = 1'b1; s.ex_r1 = 5'd7; s.em_dst = 5'd7; s.em_we = 1'b1;
        step(s, "reset_hold");
        checkOutput("reset_hold forced L3", 32'(last3), 32'(OUT_NONE));
        rst = 1'b1;

        repeat (4) step(idle, "settle");
        foreach (vecs[i]) begin
            step(vecs[i].stim, vecs[i].tag);
            checkOutput({"table ", vecs[i].tag}, 32'(last1), 32'(vecs[i].want));
        end
        repeat (4) step(idle, "settle");

        rst = 1'b0; step(idle, "rst_lu"); rst = 1'b1;
        step(lu, "lu_x5");
        repeat (4) step(idle, "lu_drain");
        checkOutput("lu L1 stall_cycles", 32'(bus1.stall_cycles), 32'd1);
        checkOutput("lu L3 stall_cycles", 32'(bus3.stall_cycles), 32'd3);
        s = lu; s.ld_dst = 5'd0; s.r1 = 5'd0;
        step(s, "lu_x0");
        s = lu; s.r1_en = 1'b0;
        step(s, "lu_rena0");
        repeat (3) step(idle, "lu_drain");
        checkOutput("no-hazard L3 stall_cycles", 32'(bus3.stall_cycles), 32'd3);

        step(lu, "lb_lu");
        s = idle; s.br = 1'b1;
        step(s, "lb_branch");
        checkOutput("lstall branch L3", 32'(last3), 32'(OUT_FLUSH));
        step(idle, "lb_after");
        checkOutput("after branch L3", 32'(last3), 32'(OUT_NONE));

        repeat (2) step(idle, "settle");
        base = seen3;
        s = idle; s.mcs = 1'b1;
        step(s, "mc_start");
        repeat (3) step(idle, "mc_wait");
        s = idle; s.mcd = 1'b1;
        step(s, "mc_done");
        checkOutput("mc freeze cycles", 32'(seen3 - base), 32'd4);
        checkOutput("mc release L3", 32'(last3), 32'(OUT_NONE));

        base = seen3;
        s = idle; s.mcs = 1'b1;
        step(s, "to_start");
        repeat (10) step(idle, "to_wait");
        checkOutput("timeout freeze cycles", 32'(seen3 - base), 32'd8);
        checkOutput("timeout flag set", 32'(bus3.mc_timeout), 32'd1);
        repeat (3) step(idle, "to_after");
        checkOutput("timeout flag sticky", 32'(bus3.mc_timeout), 32'd1);
        rst = 1'b0; step(idle, "to_reset"); rst = 1'b1;
        checkOutput("timeout flag cleared", 32'(bus3.mc_timeout), 32'd0);

        step(lu, "abort_lu");
        rst = 1'b0; step(idle, "abort_rst"); rst = 1'b1;
        step(idle, "abort_after");
        checkOutput("reset aborts lstall", 32'(last3), 32'(OUT_NONE));
        s = idle; s.mcs = 1'b1;
        step(s, "abort_mc");
        step(idle, "abort_mcwait");
        rst = 1'b0; step(idle, "abort_rst2"); rst = 1'b1;
        step(idle, "abort_after2");
        checkOutput("reset aborts mcwait", 32'(last3), 32'(OUT_NONE));

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            step(rand_in(), "random");
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
